// File: rtl/block_interleaver.sv
// Ping-pong row/column block interleaver and deinterleaver with valid/ready on both sides.
// One bank fills while the other drains; the permutation comes from the stepping of the address counters.
module block_interleaver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 8
) (
  input  logic              clk_p_i,
  input  logic              reset_i,
  input  logic              mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_first_o,
  output logic              out_last_o
);

  localparam int unsigned K  = ROWS * COLS;
  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  logic [DATA_W-1:0] mem [2][K];

  bank_state_e bank_st   [2];
  logic        bank_mode [2];
  logic        wb;
  logic        rb;

  logic [AW-1:0] wr_cnt, wr_addr, rd_cnt, rd_addr;
  logic [RW-1:0] wr_r, rd_r;
  logic [CW-1:0] wr_c, rd_c;

  logic [AW-1:0] wr_cnt_nxt, wr_addr_nxt, rd_cnt_nxt, rd_addr_nxt;
  logic [RW-1:0] wr_r_nxt, rd_r_nxt;
  logic [CW-1:0] wr_c_nxt, rd_c_nxt;

  logic in_fire;
  logic wr_mode;
  logic wr_last;
  logic rd_avail;
  logic rd_colmajor;
  logic rd_last;
  logic out_load;

  assign in_ready_o  = !reset_i && (bank_st[wb] == BANK_EMPTY || bank_st[wb] == BANK_FILLING);
  assign in_fire     = in_valid_i && in_ready_o;
  // Word 0 of a block steers with the live mode; later words use the captured one.
  assign wr_mode     = (bank_st[wb] == BANK_EMPTY) ? mode_i : bank_mode[wb];
  assign wr_last     = (wr_cnt == AW'(K - 1));
  assign rd_avail    = (bank_st[rb] == BANK_FULL) || (bank_st[rb] == BANK_DRAINING);
  assign rd_colmajor = !bank_mode[rb];
  assign rd_last     = (rd_cnt == AW'(K - 1));
  assign out_load    = (!out_valid_o || out_ready_i) && rd_avail;

  // Write address: linear for interleave, column-major scatter for deinterleave.
  always_comb begin
    wr_cnt_nxt  = wr_cnt + AW'(1);
    wr_r_nxt    = wr_r;
    wr_c_nxt    = wr_c;
    wr_addr_nxt = wr_addr + AW'(1);
    if (wr_last) begin
      wr_cnt_nxt  = '0;
      wr_r_nxt    = '0;
      wr_c_nxt    = '0;
      wr_addr_nxt = '0;
    end else if (wr_mode) begin
      if (wr_r == RW'(ROWS - 1)) begin
        wr_r_nxt    = '0;
        wr_c_nxt    = wr_c + CW'(1);
        wr_addr_nxt = AW'(wr_c) + AW'(1);
      end else begin
        wr_r_nxt    = wr_r + RW'(1);
        wr_addr_nxt = wr_addr + AW'(COLS);
      end
    end
  end

  // Read address: column-major gather for interleave, linear for deinterleave.
  always_comb begin
    rd_cnt_nxt  = rd_cnt + AW'(1);
    rd_r_nxt    = rd_r;
    rd_c_nxt    = rd_c;
    rd_addr_nxt = rd_addr + AW'(1);
    if (rd_last) begin
      rd_cnt_nxt  = '0;
      rd_r_nxt    = '0;
      rd_c_nxt    = '0;
      rd_addr_nxt = '0;
    end else if (rd_colmajor) begin
      if (rd_r == RW'(ROWS - 1)) begin
        rd_r_nxt    = '0;
        rd_c_nxt    = rd_c + CW'(1);
        rd_addr_nxt = AW'(rd_c) + AW'(1);
      end else begin
        rd_r_nxt    = rd_r + RW'(1);
        rd_addr_nxt = rd_addr + AW'(COLS);
      end
    end
  end

  // Bank storage carries no reset; bank states decide what is valid.
  always_ff @(posedge clk_p_i) begin
    if (in_fire) begin
      mem[wb][wr_addr] <= in_data_i;
    end
  end

  // Bank state machines, pointers, counters and output register.
  always_ff @(posedge clk_p_i) begin
    if (reset_i) begin
      bank_st[0]   <= BANK_EMPTY;
      bank_st[1]   <= BANK_EMPTY;
      bank_mode[0] <= 1'b0;
      bank_mode[1] <= 1'b0;
      wb           <= 1'b0;
      rb           <= 1'b0;
      wr_cnt       <= '0;
      wr_addr      <= '0;
      wr_r         <= '0;
      wr_c         <= '0;
      rd_cnt       <= '0;
      rd_addr      <= '0;
      rd_r         <= '0;
      rd_c         <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_first_o  <= 1'b0;
      out_last_o   <= 1'b0;
    end else begin
      if (in_fire) begin
        if (bank_st[wb] == BANK_EMPTY) begin
          bank_mode[wb] <= mode_i;
        end
        if (wr_last) begin
          bank_st[wb] <= BANK_FULL;
          wb          <= ~wb;
        end else begin
          bank_st[wb] <= BANK_FILLING;
        end
        wr_cnt  <= wr_cnt_nxt;
        wr_addr <= wr_addr_nxt;
        wr_r    <= wr_r_nxt;
        wr_c    <= wr_c_nxt;
      end

      if (out_load) begin
        out_valid_o <= 1'b1;
        out_data_o  <= mem[rb][rd_addr];
        out_first_o <= (rd_cnt == '0);
        out_last_o  <= rd_last;
        if (rd_last) begin
          bank_st[rb] <= BANK_EMPTY;
          rb          <= ~rb;
        end else begin
          bank_st[rb] <= BANK_DRAINING;
        end
        rd_cnt  <= rd_cnt_nxt;
        rd_addr <= rd_addr_nxt;
        rd_r    <= rd_r_nxt;
        rd_c    <= rd_c_nxt;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Scoreboard bench for block_interleaver: a reference permutation model queues expected words
// when a block completes on the input side; the output monitor pops and compares them.
module tb_block_interleaver;

  localparam int unsigned DW   = 8;
  localparam int unsigned ROWS = 5;
  localparam int unsigned COLS = 8;
  localparam int unsigned K    = ROWS * COLS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t          sb [$];
  logic [DW-1:0] cap [$];
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] blk_buf [K];
  int            blk_cnt = 0;
  logic          blk_mode = 1'b0;
  exp_t          e;
  int            src, rr, cc;
  int            cyc = 0;
  int            out_cnt = 0;
  int            first_out_cyc = 0;
  int            last_out_cyc = 0;
  int            stall_cnt = 0;
  logic          rnd_ready = 1'b0;

  block_interleaver #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk_p_i     (clk),
    .reset_i     (rst),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_first_o (out_first),
    .out_last_o  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      blk_cnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (blk_cnt == 0) blk_mode = mode;
        blk_buf[blk_cnt] = in_data;
        blk_cnt++;
        if (blk_cnt == K) begin
          for (int j = 0; j < K; j++) begin
            if (!blk_mode) begin
              rr  = j % ROWS;
              cc  = j / ROWS;
              src = rr * COLS + cc;
            end else begin
              rr  = j / COLS;
              cc  = j % COLS;
              src = cc * ROWS + rr;
            end
            sb.push_back('{data: blk_buf[src], first: (j == 0), last: (j == K - 1)});
          end
          blk_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_first", 32'(out_first), 32'(e.first));
          check("out_last", 32'(out_last), 32'(e.last));
        end
        cap.push_back(out_data);
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
    end
  end

  // Random downstream backpressure when enabled.
  always begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_word(input logic [DW-1:0] d, input logic m, input int max_wait, output logic ok);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    while (!in_ready && w < max_wait) begin
      @(posedge clk);
      #1;
      w++;
    end
    stall_cnt += w;
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic m);
    logic ok;
    send_word(d, m, 3000, ok);
    check("in_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_gappy(input logic [DW-1:0] d, input logic m);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    send(d, m);
  endtask

  task automatic drain();
    int b;
    b = 0;
    rnd_ready = 1'b0;
    while ((sb.size() != 0 || out_valid) && b < 3000) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      b++;
    end
    out_ready = 1'b1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   acc;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Interleave 0..39 with latency check.
    for (int i = 0; i < K; i++) send(DW'(i), 1'b0);
    check("lat_before", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_first", 32'(out_first), 32'd1);
    check("lat_data", 32'(out_data), 32'd0);
    drain();

    // Deinterleave the interleaved sequence back to 0..39.
    cap.delete();
    for (int i = 0; i < K; i++) send(DW'((i % ROWS) * COLS + i / ROWS), 1'b1);
    drain();
    for (int i = 0; i < K; i++) check("deint_order", 32'(cap[i]), 32'(i));

    // Chained interleave -> deinterleave of random data.
    src_q.delete();
    for (int i = 0; i < K; i++) src_q.push_back(DW'($urandom));
    cap.delete();
    for (int i = 0; i < K; i++) send(src_q[i], 1'b0);
    drain();
    begin
      logic [DW-1:0] mid [$];
      mid = cap;
      cap.delete();
      for (int i = 0; i < K; i++) send(mid[i], 1'b1);
    end
    drain();
    for (int i = 0; i < K; i++) check("chain_roundtrip", 32'(cap[i]), 32'(src_q[i]));

    // Three back-to-back blocks, modes 0,1,0, no stalls and no output bubbles.
    stall_cnt = 0;
    out_cnt = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < K; i++) send(DW'($urandom), 1'(b == 1));
    drain();
    check("b2b_stalls", 32'(stall_cnt), 32'd0);
    check("b2b_out_cnt", 32'(out_cnt), 32'(3 * K));
    check("b2b_no_gaps", 32'(last_out_cyc - first_out_cyc), 32'(3 * K - 1));

    // Backpressure: two blocks buffered, then input stalls.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3 * K; i++) begin
      send_word((i < K) ? DW'(i) : DW'($urandom), 1'b0, 5, ok);
      if (!ok) break;
      acc++;
    end
    check("bp_accepts", 32'(acc), 32'(2 * K));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < 4; h++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'd0);
      @(posedge clk);
      #1;
    end
    out_cnt = 0;
    drain();
    check("bp_drain_cnt", 32'(out_cnt), 32'(2 * K));

    // Mode toggled at word 17 with random input gaps and output backpressure.
    rnd_ready = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < K; i++) send_gappy(DW'($urandom), (i < 17) ? 1'(b & 1) : ~1'(b & 1));
    drain();

    // Reset mid-block while the previous block drains.
    for (int i = 0; i < K; i++) send(DW'(i), 1'b0);
    for (int i = 0; i < 20; i++) send(DW'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    out_cnt = 0;
    cap.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < K; i++) send(DW'(i), 1'b0);
    drain();
    check("rst_fresh_cnt", 32'(out_cnt), 32'(K));
    check("rst_fresh_w1", 32'(cap[1]), 32'd8);
    check("rst_fresh_last", 32'(cap[K-1]), 32'(K - 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
